// File: rtl/orient_controller.sv
// Per-player lightbike direction controller: buffers button turns, commits them
// on the movement tick, rejects reversals/repeats and latches crashes.
module orient_controller #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        restart,
  input  logic [NUM_PLAYERS-1:0]      btn_left,
  input  logic [NUM_PLAYERS-1:0]      btn_right,
  input  logic [NUM_PLAYERS-1:0]      btn_up,
  input  logic [NUM_PLAYERS-1:0]      btn_down,
  input  logic [NUM_PLAYERS-1:0]      crash,
  output logic [32*NUM_PLAYERS-1:0]   orient,
  output logic [NUM_PLAYERS-1:0]      alive,
  output logic [NUM_PLAYERS-1:0]      turn,
  output logic [NUM_PLAYERS-1:0]      q_full
);

  localparam int unsigned DIR_W = 32;
  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned MEM_N = 1 << PTR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam logic [DIR_W-1:0] DIR_R = DIR_W'(1);
  localparam logic [DIR_W-1:0] DIR_L = '1;
  localparam logic [DIR_W-1:0] DIR_D = DIR_W'(SCREEN_W);
  localparam logic [DIR_W-1:0] DIR_U = DIR_W'(0) - DIR_W'(SCREEN_W);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    localparam logic [DIR_W-1:0] START_DIR = ((p % 2) == 0) ? DIR_R : DIR_L;

    logic [1:0]       state_q, state_n;
    logic [DIR_W-1:0] orient_q, orient_n;
    logic             alive_q, alive_n;
    logic             turn_q, turn_n;
    logic             full_q, full_n;
    logic [PTR_W-1:0] rd_q, rd_n, wr_q, wr_n, tail_idx;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       hist_q, btn_now, edges;
    logic [DIR_W-1:0] mem [MEM_N];
    logic [DIR_W-1:0] req, ref_dir;
    logic             req_vld, push, pop;

    // Button order in the history vector: {down, up, right, left}
    assign btn_now  = {btn_down[p], btn_up[p], btn_right[p], btn_left[p]};
    assign edges    = btn_now & ~hist_q;
    assign tail_idx = (wr_q == '0) ? PTR_LAST : wr_q - PTR_W'(1);

    // Single request per cycle, down > up > right > left; checked against queue tail
    always_comb begin
      req     = DIR_L;
      req_vld = |edges;
      if (edges[3])      req = DIR_D;
      else if (edges[2]) req = DIR_U;
      else if (edges[1]) req = DIR_R;
      ref_dir = (cnt_q != '0) ? mem[tail_idx] : orient_q;
    end

    always_comb begin
      state_n  = state_q;
      orient_n = orient_q;
      rd_n     = rd_q;
      wr_n     = wr_q;
      cnt_n    = cnt_q;
      turn_n   = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      if (restart) begin
        state_n  = S_RUN;
        orient_n = START_DIR;
        rd_n     = '0;
        wr_n     = '0;
        cnt_n    = '0;
      end else begin
        case (state_q)
          S_RUN: begin
            if (crash[p]) begin
              state_n  = S_DEAD;
              orient_n = '0;
              rd_n     = '0;
              wr_n     = '0;
              cnt_n    = '0;
            end else begin
              push = req_vld && (req != ref_dir) &&
                     (req != (DIR_W'(0) - ref_dir)) && (cnt_q != CNT_FULL);
              pop  = tick && (cnt_q != '0);
              if (pop) begin
                orient_n = mem[rd_q];
                turn_n   = 1'b1;
                rd_n     = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_W'(1);
              end
              if (push) wr_n = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_W'(1);
              if (push && !pop)      cnt_n = cnt_q + CNT_W'(1);
              else if (pop && !push) cnt_n = cnt_q - CNT_W'(1);
            end
          end
          S_DEAD:  state_n = S_DEAD;
          default: state_n = S_IDLE;
        endcase
      end
      alive_n = (state_n == S_RUN);
      full_n  = (cnt_n == CNT_FULL);
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q  <= S_IDLE;
        orient_q <= '0;
        alive_q  <= 1'b0;
        turn_q   <= 1'b0;
        full_q   <= 1'b0;
        rd_q     <= '0;
        wr_q     <= '0;
        cnt_q    <= '0;
        hist_q   <= '0;
      end else begin
        state_q  <= state_n;
        orient_q <= orient_n;
        alive_q  <= alive_n;
        turn_q   <= turn_n;
        full_q   <= full_n;
        rd_q     <= rd_n;
        wr_q     <= wr_n;
        cnt_q    <= cnt_n;
        hist_q   <= btn_now;
      end
    end

    // Queue storage needs no reset; occupancy alone says which entries are valid
    always_ff @(posedge clock) begin
      if (push) mem[wr_q] <= req;
    end

    assign orient[32*p +: 32] = orient_q;
    assign alive[p]           = alive_q;
    assign turn[p]            = turn_q;
    assign q_full[p]          = full_q;
  end

endmodule

// File: tb/tb_orient_controller.sv
// Directed bench for orient_controller: default build plus a 320/4/1 build.
module tb_orient_controller;

  logic clock = 1'b0;
  logic reset, tick, restart;
  logic [1:0]   btn_left, btn_right, btn_up, btn_down, crash;
  logic [63:0]  orient;
  logic [1:0]   alive, turn, q_full;
  logic [3:0]   bl_b, br_b, bu_b, bd_b, crash_b;
  logic [127:0] orient_b;
  logic [3:0]   alive_b, turn_b, q_full_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  orient_controller u_dut (
    .clock(clock), .reset(reset), .tick(tick), .restart(restart),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .crash(crash), .orient(orient), .alive(alive), .turn(turn), .q_full(q_full)
  );

  orient_controller #(.SCREEN_W(320), .NUM_PLAYERS(4), .QUEUE_DEPTH(1)) u_dut_b (
    .clock(clock), .reset(reset), .tick(tick), .restart(restart),
    .btn_left(bl_b), .btn_right(br_b), .btn_up(bu_b), .btn_down(bd_b),
    .crash(crash_b), .orient(orient_b), .alive(alive_b), .turn(turn_b), .q_full(q_full_b)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; restart = 1'b0;
    btn_left = '0; btn_right = '0; btn_up = '0; btn_down = '0; crash = '0;
    bl_b = '0; br_b = '0; bu_b = '0; bd_b = '0; crash_b = '0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_orient0", orient[31:0], 32'h0);
    chk("rst_orient1", orient[63:32], 32'h0);
    chk("rst_alive", 32'(alive), 32'h0);
    chk("rst_turn", 32'(turn), 32'h0);
    chk("rst_qfull", 32'(q_full), 32'h0);

    // Round start: P0 right, P1 left
    restart = 1'b1; cyc(); restart = 1'b0;
    chk("start_orient0", orient[31:0], 32'h0000_0001);
    chk("start_orient1", orient[63:32], 32'hFFFF_FFFF);
    chk("start_alive", 32'(alive), 32'h3);

    // Press up together with tick: tick must not pop the entry pushed this cycle
    btn_up[0] = 1'b1; tick = 1'b1; cyc(); btn_up[0] = 1'b0;
    chk("same_cyc_no_pop", orient[31:0], 32'h0000_0001);
    chk("same_cyc_no_turn", 32'(turn), 32'h0);
    cyc(); tick = 1'b0;
    chk("up_orient0", orient[31:0], 32'hFFFF_FD80);
    chk("up_turn", 32'(turn), 32'h1);
    cyc();
    chk("up_turn_clear", 32'(turn), 32'h0);
    chk("up_hold", orient[31:0], 32'hFFFF_FD80);

    // Reversal (left) and repeat (right) while moving right are both dropped
    restart = 1'b1; cyc(); restart = 1'b0;
    btn_left[0] = 1'b1; cyc(); btn_left[0] = 1'b0;
    btn_right[0] = 1'b1; cyc(); btn_right[0] = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("rev_orient0", orient[31:0], 32'h0000_0001);
    chk("rev_turn", 32'(turn), 32'h0);
    btn_up[0] = 1'b1; cyc(); btn_up[0] = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("rev_queue_empty", orient[31:0], 32'hFFFF_FD80);

    // Simultaneous up+down: down has priority, up is not queued
    restart = 1'b1; cyc(); restart = 1'b0;
    btn_up[0] = 1'b1; btn_down[0] = 1'b1; cyc(); btn_up[0] = 1'b0; btn_down[0] = 1'b0;
    tick = 1'b1; cyc();
    chk("prio_down", orient[31:0], 32'h0000_0280);
    chk("prio_turn", 32'(turn), 32'h1);
    cyc(); tick = 1'b0;
    chk("prio_no_up", orient[31:0], 32'h0000_0280);
    chk("prio_turn_clear", 32'(turn), 32'h0);

    // Queue ordering: up, left queued; down dropped on full queue
    restart = 1'b1; cyc(); restart = 1'b0;
    btn_up[0] = 1'b1; cyc(); btn_up[0] = 1'b0;
    chk("q_one_not_full", 32'(q_full), 32'h0);
    btn_left[0] = 1'b1; cyc(); btn_left[0] = 1'b0;
    chk("q_full_after_left", 32'(q_full), 32'h1);
    btn_down[0] = 1'b1; cyc(); btn_down[0] = 1'b0;
    chk("q_full_after_down", 32'(q_full), 32'h1);
    tick = 1'b1; cyc();
    chk("q_pop1", orient[31:0], 32'hFFFF_FD80);
    chk("q_pop1_not_full", 32'(q_full), 32'h0);
    cyc();
    chk("q_pop2", orient[31:0], 32'hFFFF_FFFF);
    chk("q_pop2_turn", 32'(turn), 32'h1);
    cyc(); tick = 1'b0;
    chk("q_down_dropped", orient[31:0], 32'hFFFF_FFFF);
    chk("q_empty_no_turn", 32'(turn), 32'h0);

    // Crash + tick + pending turn on P1; crash wins
    btn_down[1] = 1'b1; cyc(); btn_down[1] = 1'b0;
    crash = 2'b10; tick = 1'b1; cyc(); crash = 2'b00;
    chk("crash_orient1", orient[63:32], 32'h0);
    chk("crash_alive", 32'(alive), 32'h1);
    chk("crash_qfull1", 32'(q_full), 32'h0);
    chk("crash_p0_indep", orient[31:0], 32'hFFFF_FFFF);
    cyc(); tick = 1'b0;
    chk("dead_holds", orient[63:32], 32'h0);
    restart = 1'b1; crash = 2'b10; cyc(); restart = 1'b0; crash = 2'b00;
    chk("restart_beats_crash", 32'(alive), 32'h3);
    chk("restart_orient1", orient[63:32], 32'hFFFF_FFFF);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("restart_q_empty1", orient[63:32], 32'hFFFF_FFFF);
    chk("restart_no_turn", 32'(turn), 32'h0);

    // Button held through restart yields no request
    btn_down[0] = 1'b1; restart = 1'b1; cyc(); restart = 1'b0;
    cyc(); tick = 1'b1; cyc(); tick = 1'b0; btn_down[0] = 1'b0;
    chk("held_no_turn", 32'(turn), 32'h0);
    chk("held_orient0", orient[31:0], 32'h0000_0001);

    // Reset with one queued entry, then IDLE ignores tick/buttons
    btn_up[0] = 1'b1; cyc(); btn_up[0] = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midrst_orient", orient[31:0] | orient[63:32], 32'h0);
    chk("midrst_alive", 32'(alive), 32'h0);
    btn_up[0] = 1'b1; tick = 1'b1; cyc(); btn_up[0] = 1'b0; tick = 1'b0;
    chk("idle_ignores", orient[31:0], 32'h0);
    chk("idle_no_turn", 32'(turn), 32'h0);
    restart = 1'b1; cyc(); restart = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("post_rst_empty", orient[31:0], 32'h0000_0001);
    chk("post_rst_no_turn", 32'(turn), 32'h0);

    // 320 / 4 players / depth 1 build
    restart = 1'b1; cyc(); restart = 1'b0;
    chk("b_start0", orient_b[31:0], 32'h0000_0001);
    chk("b_start1", orient_b[63:32], 32'hFFFF_FFFF);
    chk("b_start2", orient_b[95:64], 32'h0000_0001);
    chk("b_start3", orient_b[127:96], 32'hFFFF_FFFF);
    chk("b_alive", 32'(alive_b), 32'hF);
    bd_b[0] = 1'b1; bu_b[2] = 1'b1; cyc(); bd_b[0] = 1'b0; bu_b[2] = 1'b0;
    br_b[0] = 1'b1; cyc(); br_b[0] = 1'b0;
    chk("b_qfull", 32'(q_full_b), 32'h5);
    tick = 1'b1; cyc();
    chk("b_down320", orient_b[31:0], 32'h0000_0140);
    chk("b_up320", orient_b[95:64], 32'hFFFF_FEC0);
    chk("b_turn", 32'(turn_b), 32'h5);
    cyc(); tick = 1'b0;
    chk("b_second_dropped", orient_b[31:0], 32'h0000_0140);
    chk("b_no_turn", 32'(turn_b), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
